// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter state encoding and
// the baud-counter width helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  function automatic int baud_cnt_width(input int clk_freq, input int uart_bps);
    return $clog2(clk_freq / uart_bps);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with show-ahead read: dout holds the oldest word whenever
// empty is low. Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: flushing the pointers discards the contents.
  always_ff @(posedge sys_clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (cnt == DEPTH_C);
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter with configurable frame format and CTS flow
// control; frames start only at frame boundaries and always run to completion.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int UART_BPS   = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic                          cts_n,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output tx_state_t                     state_dbg
);

  localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int BW = baud_cnt_width(CLK_FREQ, UART_BPS);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_CNT_MAX - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  tx_state_t              state;
  tx_state_t              state_nxt;
  logic [BW-1:0]          baud_cnt;
  logic [3:0]             bit_cnt;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   par_bit;
  logic                   cts_m;
  logic                   cts_s;
  logic [DATA_BITS-1:0]   fifo_dout;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   bit_end;
  logic                   can_start;
  logic                   load;
  logic                   tx_nxt;

  // Handshake: a word is accepted on every rising edge where tx_valid and
  // tx_ready are both high; tx_ready depends only on registered fill level
  // (and reset), never on tx_valid, and words offered while full are dropped.
  assign tx_ready = sys_rst_n && !fifo_full;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .push      (tx_valid && tx_ready),
    .pop       (load),
    .din       (tx_data),
    .dout      (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Reset to "not clear" so nothing launches before the line state is known.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cts_m <= 1'b1;
      cts_s <= 1'b1;
    end else begin
      cts_m <= cts_n;
      cts_s <= cts_m;
    end
  end

  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign can_start = !fifo_empty && !cts_s;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (can_start) begin
          state_nxt = ST_START;
          load      = 1'b1;
        end
      end
      ST_START: if (bit_end) state_nxt = ST_DATA;
      ST_DATA: begin
        if (bit_end && bit_cnt == DATA_LAST)
          state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: if (bit_end) state_nxt = ST_STOP;
      ST_STOP: begin
        if (bit_end && bit_cnt == STOP_LAST) begin
          // Chain straight into the next start bit when more data is waiting.
          state_nxt = can_start ? ST_START : ST_IDLE;
          load      = can_start;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_nxt = 1'b1;
    busy   = (state != ST_IDLE);
    case (state)
      ST_START:  tx_nxt = 1'b0;
      ST_DATA:   tx_nxt = shift_reg[0];
      ST_PARITY: tx_nxt = par_bit;
      default:   tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      tx        <= 1'b1;
    end else begin
      tx <= tx_nxt;
      if (state == ST_IDLE || bit_end) baud_cnt <= '0;
      else                             baud_cnt <= baud_cnt + 1'b1;
      if (state_nxt != state) bit_cnt <= '0;
      else if (bit_end)       bit_cnt <= bit_cnt + 1'b1;
      if (load) begin
        shift_reg <= fifo_dout;
        par_bit   <= (PARITY == PAR_EVEN) ? ^fifo_dout : ~^fifo_dout;
      end else if (state == ST_DATA && bit_end) begin
        shift_reg <= shift_reg >> 1;
      end
    end
  end

  assign state_dbg = state;

endmodule
